// File: rtl/arc4_pkg.sv
// Shared types and defaults for the ARC4 batch run sequencer.
//   ARC4_KEY_W_DEF   : default engine key width
//   arc4_seq_state_t : sequencer FSM state encoding
package arc4_pkg;

    localparam int ARC4_KEY_W_DEF = 24;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_FIRE   = 3'd2,
        ST_RUN_LO = 3'd3,
        ST_RUN_HI = 3'd4,
        ST_NEXT   = 3'd5,
        ST_DRAIN  = 3'd6,
        ST_FIN    = 3'd7
    } arc4_seq_state_t;

endpackage

// File: rtl/arc4_cyc_ctr.sv
// Saturating up-counter with synchronous clear (clear has priority over enable).
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : zero the counter
//   en       : count this cycle (holds at all-ones)
//   cnt      : registered count value
module arc4_cyc_ctr #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ZERO_C = {W{1'b0}};
    localparam logic [W-1:0] ONES_C = {W{1'b1}};
    localparam logic [W-1:0] ONE_C  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_r;

    // Count register: clear, saturating increment, or hold
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= ZERO_C;
        end else if (clr) begin
            cnt_r <= ZERO_C;
        end else if (en && (cnt_r != ONES_C)) begin
            cnt_r <= cnt_r + ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/arc4_batch_seq.sv
// ARC4 batch run sequencer: walks an external arc4 engine through num_keys
// consecutive keys starting at base_key, issuing one single-cycle eng_en per run.
// Optional feature macro: ARC4_SEQ_CYCLE_CNT_EN enables the busy-cycle counter;
// without it cycle_cnt is tied to zero.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start, abort       : batch control (start only honoured in IDLE)
//   base_key, num_keys : batch parameters, captured on accepted start
//   eng_rdy            : engine ready (low while a run is in progress)
//   eng_en, eng_key    : engine start pulse and key
//   cur_key, runs_done : current key and completed-run count
//   busy, done, aborted: status; done pulses once per batch
//   cycle_cnt          : non-IDLE clocks of the current/last batch
module arc4_batch_seq
    import arc4_pkg::*;
#(
    parameter int KEY_W = ARC4_KEY_W_DEF,
    parameter int CNT_W = 16,
    parameter int CYC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [KEY_W-1:0] base_key,
    input  logic [CNT_W-1:0] num_keys,
    input  logic             eng_rdy,
    output logic             eng_en,
    output logic [KEY_W-1:0] eng_key,
    output logic [KEY_W-1:0] cur_key,
    output logic [CNT_W-1:0] runs_done,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CYC_W-1:0] cycle_cnt
);

    localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [KEY_W-1:0] KEY_ZERO_C = {KEY_W{1'b0}};
    localparam logic [KEY_W-1:0] KEY_ONE_C  = {{(KEY_W-1){1'b0}}, 1'b1};

    arc4_seq_state_t  state_r, state_next_s;
    logic [CNT_W-1:0] limit_r, runs_done_r, runs_inc_s;
    logic [KEY_W-1:0] cur_key_r;
    logic             abort_lat_r, drain_r, aborted_r;
    logic             eng_en_r, busy_r, done_r;
    logic             start_acc_s, step_s, abort_fin_s;

    assign start_acc_s = (state_r == ST_IDLE) && start;
    // DRAIN performs the same end-of-run bookkeeping as NEXT.
    assign step_s      = (state_r == ST_NEXT) || (state_r == ST_DRAIN);
    // runs_done never passes the limit
    assign runs_inc_s  = (runs_done_r == limit_r) ? runs_done_r : (runs_done_r + CNT_ONE_C);

    // Next-state decode; abort_fin_s flags entry into FIN through an abort
    always_comb begin
        state_next_s = state_r;
        abort_fin_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = (num_keys == CNT_ZERO_C) ? ST_FIN : ST_ARM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (abort) begin
                    state_next_s = ST_FIN;
                    abort_fin_s  = 1'b1;
                end else if (eng_rdy) begin
                    state_next_s = ST_FIRE;
                end else begin
                    state_next_s = ST_ARM;
                end
            end
            ST_FIRE: begin
                state_next_s = ST_RUN_LO;
            end
            ST_RUN_LO: begin
                // ready dropping is the engine's acknowledgement of eng_en
                if (!eng_rdy) begin
                    state_next_s = ST_RUN_HI;
                end else begin
                    state_next_s = ST_RUN_LO;
                end
            end
            ST_RUN_HI: begin
                if (eng_rdy) begin
                    state_next_s = drain_r ? ST_DRAIN : ST_NEXT;
                end else begin
                    state_next_s = ST_RUN_HI;
                end
            end
            ST_NEXT: begin
                if (abort_lat_r || abort) begin
                    state_next_s = ST_FIN;
                    abort_fin_s  = 1'b1;
                end else if (runs_inc_s == limit_r) begin
                    state_next_s = ST_FIN;
                end else begin
                    state_next_s = ST_ARM;
                end
            end
            ST_DRAIN: begin
                state_next_s = ST_FIN;
                abort_fin_s  = 1'b1;
            end
            ST_FIN: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State and registered status outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            eng_en_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            eng_en_r <= (state_next_s == ST_FIRE);
            busy_r   <= (state_next_s != ST_IDLE);
            done_r   <= (state_next_s == ST_FIN);
        end
    end

    // Batch datapath: key, limit, run count and abort bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_key_r   <= KEY_ZERO_C;
            limit_r     <= CNT_ZERO_C;
            runs_done_r <= CNT_ZERO_C;
            aborted_r   <= 1'b0;
            abort_lat_r <= 1'b0;
            drain_r     <= 1'b0;
        end else if (start_acc_s) begin
            cur_key_r   <= base_key;
            limit_r     <= num_keys;
            runs_done_r <= CNT_ZERO_C;
            aborted_r   <= 1'b0;
            abort_lat_r <= 1'b0;
            drain_r     <= 1'b0;
        end else begin
            if (step_s) begin
                runs_done_r <= runs_inc_s;
                cur_key_r   <= cur_key_r + KEY_ONE_C;
            end
            if (abort_fin_s) begin
                aborted_r <= 1'b1;
            end
            // an abort during a run is held until that run has been accounted for
            if (abort && (state_r inside {ST_FIRE, ST_RUN_LO, ST_RUN_HI, ST_NEXT})) begin
                abort_lat_r <= 1'b1;
            end
            if (abort && (state_r == ST_RUN_LO)) begin
                drain_r <= 1'b1;
            end
        end
    end

    assign eng_en    = eng_en_r;
    assign eng_key   = cur_key_r;
    assign cur_key   = cur_key_r;
    assign runs_done = runs_done_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign aborted   = aborted_r;

`ifdef ARC4_SEQ_CYCLE_CNT_EN
    arc4_cyc_ctr #(
        .W(CYC_W)
    ) u_cyc_ctr (
        .clk(clk),
        .rst(rst),
        .clr(start_acc_s),
        .en (busy_r),
        .cnt(cycle_cnt)
    );
`else
    assign cycle_cnt = {CYC_W{1'b0}};
`endif

endmodule
